// File: rtl/cd_spi_csr_bridge.sv
// ----------------------------------------------------------------------------
// cd_spi_csr_bridge
//
// SPI mode-0 slave that masters the cdbus 5-bit address / 8-bit data CSR bus.
// An external MCU uses it to read and write CDBUS registers and to burst data
// through the TX/RX RAM data registers. The SPI pins are oversampled in the
// system clock domain, so the whole block runs on a single clock.
//
// Frame: command byte {wr, 2'b00, addr[4:0]}, then any number of data bytes.
// The frame ends when nss rises.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on sclk/nss/mosi (2..3)
//   RD_LAT       clk cycles from o_csr_read to valid i_csr_readdata (1..2)
//
// Ports:
//   i_clk            system clock (sclk must be <= clk/8)
//   i_reset          synchronous reset, active-high
//   i_spi_sclk       SPI clock, idle low
//   i_spi_nss        SPI select, active-low
//   i_spi_mosi       SPI data in, MSB first
//   o_spi_miso       SPI data out, high-Z while synced nss is high
//   o_chip_select    synced ~nss, feeds cdbus chip_select
//   o_csr_address    CSR address
//   o_csr_read       one-cycle read strobe
//   i_csr_readdata   read data, valid RD_LAT cycles after o_csr_read
//   o_csr_write      one-cycle write strobe
//   o_csr_writedata  write data, valid while o_csr_write is high
//
// Optional feature: define CD_SPI_ADDR_INC_EN to auto-increment the CSR
// address (modulo 32) after every csr_write and every data-byte csr_read.
// ----------------------------------------------------------------------------
module cd_spi_csr_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_spi_sclk,
    input  logic       i_spi_nss,
    input  logic       i_spi_mosi,
    output logic       o_spi_miso,
    output logic       o_chip_select,
    output logic [4:0] o_csr_address,
    output logic       o_csr_read,
    input  logic [7:0] i_csr_readdata,
    output logic       o_csr_write,
    output logic [7:0] o_csr_writedata
);

    typedef enum logic [1:0] {StIdle, StCmd, StWr, StRd} state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_nss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_q;
    logic                   r_nss_q;
    logic                   r_chip_select;

    logic w_sclk_s;
    logic w_nss_s;
    logic w_mosi_s;
    logic w_edge_en;
    logic w_rise;
    logic w_fall;
    logic w_nss_fall;
    logic w_nss_rise;

    // nss resets to the "selected" level: after a reset in the middle of a
    // frame no false falling edge is seen, so the bridge waits for a fresh one.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sclk_sync   <= '0;
            r_nss_sync    <= '0;
            r_mosi_sync   <= '0;
            r_sclk_q      <= 1'b0;
            r_nss_q       <= 1'b0;
            r_chip_select <= 1'b0;
        end else begin
            r_sclk_sync   <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
            r_nss_sync    <= {r_nss_sync[SYNC_STAGES-2:0], i_spi_nss};
            r_mosi_sync   <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            r_sclk_q      <= w_sclk_s;
            r_nss_q       <= w_nss_s;
            r_chip_select <= ~w_nss_s;
        end
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_nss_s  = r_nss_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // Gate with the delayed nss so a sclk rise coincident with the nss rise
    // is still processed before the FSM drops back to idle.
    assign w_edge_en  = ~r_nss_q;
    assign w_rise     = w_sclk_s & ~r_sclk_q & w_edge_en;
    assign w_fall     = ~w_sclk_s & r_sclk_q & w_edge_en;
    assign w_nss_fall = ~w_nss_s & r_nss_q;
    assign w_nss_rise = w_nss_s & ~r_nss_q;

    // ------------------------------------------------------------------
    // Read latency pipeline: w_rd_valid marks the cycle readdata is valid
    // ------------------------------------------------------------------
    logic [RD_LAT-1:0] r_rd_dly;
    logic              w_rd_valid;
    logic              r_csr_read;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_dly <= '0;
        end else begin
            r_rd_dly[0] <= r_csr_read;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_rd_dly[i] <= r_rd_dly[i-1];
            end
        end
    end

    assign w_rd_valid = r_rd_dly[RD_LAT-1];

    // ------------------------------------------------------------------
    // Main FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_sh;
    logic [7:0] r_tx_sh;
    logic       r_miso;
    logic [4:0] r_csr_address;
    logic       r_csr_write;
    logic [7:0] r_csr_writedata;

    logic [7:0] w_rx_byte;
    logic       w_byte_done;

    assign w_rx_byte   = {r_rx_sh, w_mosi_s};
    assign w_byte_done = w_rise & (r_bit_cnt == 3'd7);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= StIdle;
            r_bit_cnt       <= 3'd0;
            r_rx_sh         <= 7'd0;
            r_tx_sh         <= 8'd0;
            r_miso          <= 1'b0;
            r_csr_address   <= 5'd0;
            r_csr_read      <= 1'b0;
            r_csr_write     <= 1'b0;
            r_csr_writedata <= 8'd0;
        end else begin
            r_csr_read  <= 1'b0;
            r_csr_write <= 1'b0;
`ifdef CD_SPI_ADDR_INC_EN
            // Step past the register just accessed; 5-bit add wraps 31 -> 0.
            if (r_csr_read || r_csr_write) begin
                r_csr_address <= r_csr_address + 5'd1;
            end
`endif
            case (r_state)
                StIdle: begin
                    if (w_nss_fall) begin
                        r_state   <= StCmd;
                        r_bit_cnt <= 3'd0;
                        r_miso    <= 1'b0;
                    end
                end
                StCmd: begin
                    if (w_rise) begin
                        r_rx_sh   <= w_rx_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_byte_done) begin
                            r_csr_address <= w_rx_byte[4:0];
                            if (w_rx_byte[7]) begin
                                r_state <= StWr;
                            end else begin
                                r_state    <= StRd;
                                r_csr_read <= 1'b1;
                            end
                        end
                    end
                end
                StWr: begin
                    if (w_rise) begin
                        r_rx_sh   <= w_rx_byte[6:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_byte_done) begin
                            r_csr_writedata <= w_rx_byte;
                            r_csr_write     <= 1'b1;
                        end
                    end
                end
                StRd: begin
                    if (w_rise) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        // Prefetch the next byte; surplus reads are harmless.
                        if (w_byte_done) begin
                            r_csr_read <= 1'b1;
                        end
                    end
                    if (w_rd_valid && w_fall) begin
                        r_miso  <= i_csr_readdata[7];
                        r_tx_sh <= {i_csr_readdata[6:0], 1'b0};
                    end else if (w_rd_valid) begin
                        r_tx_sh <= i_csr_readdata;
                    end else if (w_fall) begin
                        r_miso  <= r_tx_sh[7];
                        r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                    end
                end
                default: r_state <= StIdle;
            endcase

            // End of frame overrides everything above except the final rise.
            if (w_nss_rise) begin
                r_state   <= StIdle;
                r_bit_cnt <= 3'd0;
                r_tx_sh   <= 8'd0;
                r_miso    <= 1'b0;
            end
        end
    end

    assign o_spi_miso      = w_nss_s ? 1'bz : r_miso;
    assign o_chip_select   = r_chip_select;
    assign o_csr_address   = r_csr_address;
    assign o_csr_read      = r_csr_read;
    assign o_csr_write     = r_csr_write;
    assign o_csr_writedata = r_csr_writedata;

endmodule

// File: tb/tb_cd_spi_csr_bridge.sv
// ----------------------------------------------------------------------------
// tb_cd_spi_csr_bridge
//
// Directed bench for cd_spi_csr_bridge. A bit-banged SPI master drives frames
// with sclk = clk/8; a negedge monitor counts and logs CSR strobes and plays
// the CSR slave by presenting read data from a small table.
// ----------------------------------------------------------------------------
module tb_cd_spi_csr_bridge;

    logic       clk;
    logic       reset;
    logic       spi_sclk;
    logic       spi_nss;
    logic       spi_mosi;
    wire        spi_miso;
    logic       chip_select;
    logic [4:0] csr_address;
    logic       csr_read;
    logic [7:0] csr_readdata;
    logic       csr_write;
    logic [7:0] csr_writedata;

    cd_spi_csr_bridge #(
        .SYNC_STAGES(2),
        .RD_LAT     (1)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_spi_sclk     (spi_sclk),
        .i_spi_nss      (spi_nss),
        .i_spi_mosi     (spi_mosi),
        .o_spi_miso     (spi_miso),
        .o_chip_select  (chip_select),
        .o_csr_address  (csr_address),
        .o_csr_read     (csr_read),
        .i_csr_readdata (csr_readdata),
        .o_csr_write    (csr_write),
        .o_csr_writedata(csr_writedata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Strobe monitor / CSR slave model
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         overlap = 0;
    logic [4:0] wr_addr_log[16];
    logic [7:0] wr_data_log[16];
    logic [4:0] rd_addr_log[16];
    logic [7:0] rd_tab[4];

    always @(negedge clk) begin
        if (csr_read && csr_write) overlap++;
        if (csr_write) begin
            if (wr_cnt < 16) begin
                wr_addr_log[wr_cnt] = csr_address;
                wr_data_log[wr_cnt] = csr_writedata;
            end
            wr_cnt++;
        end
        if (csr_read) begin
            if (rd_cnt < 16) rd_addr_log[rd_cnt] = csr_address;
            csr_readdata = (rd_cnt < 4) ? rd_tab[rd_cnt] : 8'h00;
            rd_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        wr_cnt  = 0;
        rd_cnt  = 0;
        overlap = 0;
    endtask

    task automatic start_frame();
        spi_nss = 1'b0;
        tick(4);
    endtask

    task automatic end_frame();
        tick(4);
        spi_nss = 1'b1;
        tick(8);
    endtask

    // Shift out the top nbits of tx, sampling miso just before each rise.
    // nss_on_last raises nss together with the final rise.
    task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit nss_on_last,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            tick(4);
            rx[i]    = spi_miso;
            spi_sclk = 1'b1;
            if (nss_on_last && i == 8 - nbits) spi_nss = 1'b1;
            tick(4);
            spi_sclk = 1'b0;
        end
    endtask

    logic [7:0] rx;

    initial begin
        reset        = 1'b1;
        spi_sclk     = 1'b0;
        spi_nss      = 1'b1;
        spi_mosi     = 1'b0;
        csr_readdata = 8'h00;
        for (int i = 0; i < 4; i++) rd_tab[i] = 8'h00;

        // Reset state
        tick(3);
        check("rst_read", {31'd0, csr_read}, 32'd0);
        check("rst_write", {31'd0, csr_write}, 32'd0);
        check("rst_addr", {27'd0, csr_address}, 32'd0);
        check("rst_wdata", {24'd0, csr_writedata}, 32'd0);
        check("rst_cs", {31'd0, chip_select}, 32'd0);
        reset = 1'b0;
        tick(8);

        // Write frame 0x83, 0x5A
        clear_counts();
        start_frame();
        spi_byte(8'h83, 8, 1'b0, rx);
        check("wr_cs_active", {31'd0, chip_select}, 32'd1);
        spi_byte(8'h5A, 8, 1'b0, rx);
        end_frame();
        check("wr_count", wr_cnt, 1);
        check("wr_data", {24'd0, wr_data_log[0]}, 32'h5A);
        check("wr_addr", {27'd0, wr_addr_log[0]}, 32'd3);
        check("wr_no_read", rd_cnt, 0);
        check("wr_cs_idle", {31'd0, chip_select}, 32'd0);

        // Read frame 0x01, 0x00, 0x00 with readdata A5 then 3C
        clear_counts();
        rd_tab[0] = 8'hA5;
        rd_tab[1] = 8'h3C;
        rd_tab[2] = 8'hEE;
        start_frame();
        spi_byte(8'h01, 8, 1'b0, rx);
        spi_byte(8'h00, 8, 1'b0, rx);
        check("rd_byte0", {24'd0, rx}, 32'hA5);
        spi_byte(8'h00, 8, 1'b0, rx);
        check("rd_byte1", {24'd0, rx}, 32'h3C);
        end_frame();
        check("rd_count", rd_cnt, 3);
        check("rd_addr0", {27'd0, rd_addr_log[0]}, 32'd1);
`ifdef CD_SPI_ADDR_INC_EN
        check("rd_addr2", {27'd0, rd_addr_log[2]}, 32'd3);
`else
        check("rd_addr2", {27'd0, rd_addr_log[2]}, 32'd1);
`endif
        check("rd_no_write", wr_cnt, 0);

        // Burst write 0x85 + 4x 0x11
        clear_counts();
        start_frame();
        spi_byte(8'h85, 8, 1'b0, rx);
        for (int b = 0; b < 4; b++) spi_byte(8'h11, 8, 1'b0, rx);
        end_frame();
        check("burst_count", wr_cnt, 4);
        for (int b = 0; b < 4; b++) begin
            check("burst_data", {24'd0, wr_data_log[b]}, 32'h11);
`ifdef CD_SPI_ADDR_INC_EN
            check("burst_addr", {27'd0, wr_addr_log[b]}, 32'd5 + 32'(b));
`else
            check("burst_addr", {27'd0, wr_addr_log[b]}, 32'd5);
`endif
        end

`ifdef CD_SPI_ADDR_INC_EN
        // Address wrap 31 -> 0
        clear_counts();
        start_frame();
        spi_byte(8'h9F, 8, 1'b0, rx);
        spi_byte(8'hAA, 8, 1'b0, rx);
        spi_byte(8'hBB, 8, 1'b0, rx);
        end_frame();
        check("wrap_count", wr_cnt, 2);
        check("wrap_addr0", {27'd0, wr_addr_log[0]}, 32'd31);
        check("wrap_addr1", {27'd0, wr_addr_log[1]}, 32'd0);
        check("wrap_data1", {24'd0, wr_data_log[1]}, 32'hBB);
`endif

        // Partial byte then a good frame
        clear_counts();
        start_frame();
        spi_byte(8'h84, 8, 1'b0, rx);
        spi_byte(8'hF0, 5, 1'b0, rx);
        end_frame();
        check("partial_no_write", wr_cnt, 0);
        start_frame();
        spi_byte(8'h84, 8, 1'b0, rx);
        spi_byte(8'h77, 8, 1'b0, rx);
        end_frame();
        check("after_partial_count", wr_cnt, 1);
        check("after_partial_data", {24'd0, wr_data_log[0]}, 32'h77);
        check("after_partial_addr", {27'd0, wr_addr_log[0]}, 32'd4);

        // Reset after the 3rd data bit of a write
        clear_counts();
        start_frame();
        spi_byte(8'h86, 8, 1'b0, rx);
        spi_byte(8'hC3, 3, 1'b0, rx);
        reset = 1'b1;
        tick(1);
        check("midrst_addr", {27'd0, csr_address}, 32'd0);
        check("midrst_wdata", {24'd0, csr_writedata}, 32'd0);
        check("midrst_cs", {31'd0, chip_select}, 32'd0);
        check("midrst_strobes", {30'd0, csr_read, csr_write}, 32'd0);
        reset = 1'b0;
        spi_byte(8'h1F, 5, 1'b0, rx);
        end_frame();
        check("midrst_no_write", wr_cnt, 0);
        start_frame();
        spi_byte(8'h82, 8, 1'b0, rx);
        spi_byte(8'h3C, 8, 1'b0, rx);
        end_frame();
        check("postrst_count", wr_cnt, 1);
        check("postrst_data", {24'd0, wr_data_log[0]}, 32'h3C);
        check("postrst_addr", {27'd0, wr_addr_log[0]}, 32'd2);

        // nss high, sclk toggling 16 times
        clear_counts();
        for (int t = 0; t < 16; t++) begin
            spi_mosi = t[0];
            spi_sclk = ~spi_sclk;
            tick(4);
        end
        spi_sclk = 1'b0;
        tick(4);
        check("idle_strobes", wr_cnt + rd_cnt, 0);
        check("idle_cs", {31'd0, chip_select}, 32'd0);

        // Read-only frame: command byte only
        clear_counts();
        start_frame();
        spi_byte(8'h02, 8, 1'b0, rx);
        end_frame();
        check("rdonly_count", rd_cnt, 1);

        // nss rises together with the 8th rise of the data byte
        clear_counts();
        start_frame();
        spi_byte(8'h87, 8, 1'b0, rx);
        spi_byte(8'h44, 8, 1'b1, rx);
        tick(10);
        check("edge_nss_count", wr_cnt, 1);
        check("edge_nss_data", {24'd0, wr_data_log[0]}, 32'h44);
        check("edge_nss_addr", {27'd0, wr_addr_log[0]}, 32'd7);

        check("no_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
